fetch_prefetch_unit: RTL

//  Parametrised successor to the single-cycle fetch stage: issues in-order instruction-memory reads,

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 72 +++++++
 rtl/fetch_prefetch_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fetch_pkg                                                    |
// | Description : Shared defaults and the queue entry layout for the           |
// |               prefetching fetch unit.                                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package fetch_pkg;

   localparam int         ADDR_W_DEF  = 16;
   localparam int         INSTR_W_DEF = 16;
   localparam int         INC_DEF     = 2;
   localparam logic [3:0] HALT_OP_DEF = 4'hF;

   // One decoded-ready fetch result at the default widths
   typedef struct packed {
      logic [INSTR_W_DEF-1:0] instr;
      logic [ADDR_W_DEF-1:0]  pc;
      logic [ADDR_W_DEF-1:0]  pc_plus;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_queue                                                  |
// | Description : Synchronous FIFO of fetch entries with flush and occupancy.  |
// |               Head is forced to zero while empty.                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module fetch_queue
   import fetch_pkg::*;
#(
   parameter type T     = fetch_entry_t,
   parameter int  DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  T                       push_data,
   input  logic                   pop,
   output logic                   valid,
   output T                       head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int               PTR_W  = $clog2(DEPTH);
   localparam logic [PTR_W:0]   C_FULL = DEPTH[PTR_W:0];

   T                 r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   // A pop frees a slot in the same cycle, so push+pop at full is allowed
   assign w_pop  = pop & (r_count != '0);
   assign w_push = push & ((r_count != C_FULL) | w_pop);

   // Entry storage; validity is tracked by the pointers, so no reset needed
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign valid = (r_count != '0);
   assign head  = valid ? r_mem[r_rd_ptr] : T'('0);
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_prefetch_unit                                          |
// | Description : In-order instruction prefetcher. Issues memory reads under   |
// |               a credit limit, queues returned words, hands them to decode, |
// |               drops stale responses after a redirect and stops on HALT.    |
// |               Optional perf counters: define FETCH_PERF_CNT_EN.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INSTR_W  = INSTR_W_DEF,
   parameter int                DEPTH    = 4,
   parameter int                INC      = INC_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0]        HALT_OP  = HALT_OP_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               dec_valid,
   input  logic               dec_ready,
   output logic [INSTR_W-1:0] dec_instr,
   output logic [ADDR_W-1:0]  dec_pc,
   output logic [ADDR_W-1:0]  dec_pc_plus,
   output logic               halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_bubble,
   output logic [31:0]        perf_redirect
`endif
);

   localparam int                CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] C_INC   = ADDR_W'(INC);
   localparam logic [CNT_W:0]    C_DEPTH = (CNT_W+1)'(DEPTH);

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
      logic [ADDR_W-1:0]  pc_plus;
   } entry_t;

   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_ret_pc;
   logic [CNT_W-1:0]  r_inflight;
   logic [CNT_W-1:0]  r_drop_cnt;
   logic              r_halted;

   logic [ADDR_W-1:0] w_fetch_pc_inc;
   logic [ADDR_W-1:0] w_ret_pc_inc;
   logic [CNT_W-1:0]  w_inflight_nxt;
   logic [CNT_W-1:0]  w_q_count;
   logic              w_grant;
   logic              w_stale;
   logic              w_keep;
   logic              w_halt_word;
   entry_t            w_push_entry;
   entry_t            w_head;

   assign w_fetch_pc_inc = r_fetch_pc + C_INC;
   assign w_ret_pc_inc   = r_ret_pc + C_INC;

   // Queued plus outstanding words never exceed DEPTH, so every return has a slot
   assign imem_req  = !r_halted && !rst && !redirect &&
                      (({1'b0, w_q_count} + {1'b0, r_inflight}) < C_DEPTH);
   assign imem_addr = r_fetch_pc;
   assign w_grant   = imem_req & imem_gnt;

   // Stale returns are counted off first; while halted everything is discarded
   assign w_stale     = imem_rvalid & (r_drop_cnt != '0);
   assign w_keep      = imem_rvalid & ~w_stale & ~r_halted & ~redirect;
   assign w_halt_word = w_keep & (imem_rdata[INSTR_W-1 -: 4] == HALT_OP);

   assign w_inflight_nxt = r_inflight + CNT_W'(w_grant) - CNT_W'(imem_rvalid);

   assign w_push_entry = '{instr: imem_rdata, pc: r_ret_pc, pc_plus: w_ret_pc_inc};

   // Fetch/return PCs, credit, stale-drop and halt state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_ret_pc   <= RESET_PC;
         r_inflight <= '0;
         r_drop_cnt <= '0;
         r_halted   <= 1'b0;
      end else begin
         r_inflight <= w_inflight_nxt;
         if (redirect) begin
            // Everything still outstanding after this edge belongs to the old path
            r_fetch_pc <= redirect_pc;
            r_ret_pc   <= redirect_pc;
            r_drop_cnt <= w_inflight_nxt;
            r_halted   <= 1'b0;
         end else begin
            if (w_grant) begin
               r_fetch_pc <= w_fetch_pc_inc;
            end
            if (w_keep) begin
               r_ret_pc <= w_ret_pc_inc;
            end
            if (w_stale) begin
               r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            end
            if (w_halt_word) begin
               r_halted <= 1'b1;
            end
         end
      end
   end

   fetch_queue #(
      .T     (entry_t),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .push      (w_keep),
      .push_data (w_push_entry),
      .pop       (dec_ready),
      .valid     (dec_valid),
      .head      (w_head),
      .count     (w_q_count)
   );

   assign dec_instr   = w_head.instr;
   assign dec_pc      = w_head.pc;
   assign dec_pc_plus = w_head.pc_plus;
   assign halted      = r_halted;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_bubble;
   logic [31:0] r_perf_redirect;

   // Saturating bubble and redirect counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_bubble   <= '0;
         r_perf_redirect <= '0;
      end else begin
         if (dec_ready && !dec_valid && !r_halted && (r_perf_bubble != '1)) begin
            r_perf_bubble <= r_perf_bubble + 32'd1;
         end
         if (redirect && (r_perf_redirect != '1)) begin
            r_perf_redirect <= r_perf_redirect + 32'd1;
         end
      end
   end

   assign perf_bubble   = r_perf_bubble;
   assign perf_redirect = r_perf_redirect;
`endif

`ifndef SYNTHESIS
   // A response with nothing outstanding is a memory protocol violation
   always_ff @(posedge clk) begin
      if (!rst && imem_rvalid) begin
         assert (r_inflight != '0);
      end
   end
`endif

endmodule
`default_nettype wire
